// File: rtl/pmem_norm_if.sv
// Bundles the pmem read port and the normalized-vector output stream of pmem_norm_reader.
interface pmem_norm_if #(
    parameter int col     = 8,
    parameter int bw_psum = 12,
    parameter int add_w   = 4,
    parameter int frac    = 12
);
    localparam int sum_w = bw_psum + $clog2(col);
    localparam int nw    = frac + 2;

    logic                   pmem_rd;
    logic [add_w-1:0]       pmem_add;
    logic [bw_psum*col-1:0] pmem_dout;
    logic [nw*col-1:0]      norm_out;
    logic [sum_w-1:0]       sum_out;
    logic                   norm_valid;
    logic                   norm_ready;

    modport master (
        output pmem_rd, pmem_add, norm_out, sum_out, norm_valid,
        input  pmem_dout, norm_ready
    );

    modport slave (
        input  pmem_rd, pmem_add, norm_out, sum_out, norm_valid,
        output pmem_dout, norm_ready
    );
endinterface

// File: rtl/pmem_norm_reader.sv
// Walks pmem, sums |lane| per psum vector and divides each lane by that sum (restoring divider).
// Define NORM_ROUND_EN for round-half-up quotients; default build truncates.
module pmem_norm_reader #(
    parameter int col     = 8,
    parameter int bw_psum = 12,
    parameter int add_w   = 4,
    parameter int frac    = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [add_w:0]   i_num_vec,
    input  logic             i_sign_mode,
    pmem_norm_if.master      bus,
    output logic             o_busy,
    output logic             o_done
);
    localparam int sum_w  = bw_psum + $clog2(col);
    localparam int nw     = frac + 2;
    localparam int dvd_w  = sum_w + frac;
    localparam int lane_w = (col > 1) ? $clog2(col) : 1;
    localparam int step_w = $clog2(frac + 1);

    localparam logic [lane_w-1:0] LANE_LAST = lane_w'(col - 1);
    localparam logic [step_w-1:0] STEP_LAST = step_w'(frac);
    localparam logic [frac:0]     Q_MAX     = {1'b1, {frac{1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_SUM  = 3'd3;
    localparam logic [2:0] S_DIV  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    function automatic logic [bw_psum-1:0] lane_mag(input logic [bw_psum-1:0] v, input logic sm);
        return (sm && v[bw_psum-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [dvd_w-1:0] dividend(input logic [bw_psum-1:0] mag,
                                                  input logic [sum_w-1:0]   s);
        logic [dvd_w-1:0] d;
        d = '0;
        d[bw_psum+frac-1:frac] = mag;
`ifdef NORM_ROUND_EN
        d = d + dvd_w'(s >> 1);
`else
        d = d + dvd_w'(s & '0);
`endif
        return d;
    endfunction

    function automatic logic signed [nw-1:0] signed_norm(input logic [frac:0] q, input logic neg);
        logic [nw-1:0] m;
        m = {1'b0, (q > Q_MAX) ? Q_MAX : q};
        return neg ? $signed(-m) : $signed(m);
    endfunction

    logic [2:0]                r_state;
    logic [add_w:0]            r_idx;
    logic [add_w:0]            r_num_vec;
    logic                      r_sign_mode;
    logic [add_w-1:0]          r_add;
    logic [bw_psum-1:0]        r_lanes [col];
    logic [sum_w-1:0]          r_sum;
    logic signed [nw-1:0]      r_norm  [col];
    logic [sum_w-1:0]          r_rem;
    logic [frac:0]             r_low;
    logic [frac-1:0]           r_q;
    logic                      r_neg;
    logic [lane_w-1:0]         r_lane;
    logic [step_w-1:0]         r_step;

    logic [sum_w-1:0]          w_sum;
    logic [sum_w:0]            w_shift;
    logic                      w_ge;
    logic [sum_w-1:0]          w_rem_nxt;
    logic [frac:0]             w_q;
    logic [lane_w-1:0]         w_nxt_lane;
    logic [lane_w-1:0]         w_load_idx;
    logic [sum_w-1:0]          w_load_sum;
    logic [dvd_w-1:0]          w_dvd;
    logic [add_w:0]            w_idx_nxt;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < col; k++)
            w_sum = w_sum + sum_w'(lane_mag(r_lanes[k], r_sign_mode));
    end

    // One restoring step: shift in the next dividend bit, subtract the sum if it fits.
    always_comb begin
        w_shift    = {r_rem, r_low[frac]};
        w_ge       = (w_shift >= {1'b0, r_sum});
        w_rem_nxt  = w_ge ? (w_shift[sum_w-1:0] - r_sum) : w_shift[sum_w-1:0];
        w_q        = {r_q, w_ge};
        w_nxt_lane = (r_lane == LANE_LAST) ? '0 : r_lane + 1'b1;
        w_load_idx = (r_state == S_SUM) ? '0 : w_nxt_lane;
        w_load_sum = (r_state == S_SUM) ? w_sum : r_sum;
        w_dvd      = dividend(lane_mag(r_lanes[w_load_idx], r_sign_mode), w_load_sum);
        w_idx_nxt  = r_idx + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_num_vec   <= '0;
            r_sign_mode <= 1'b0;
            r_add       <= '0;
            r_sum       <= '0;
            r_rem       <= '0;
            r_low       <= '0;
            r_q         <= '0;
            r_neg       <= 1'b0;
            r_lane      <= '0;
            r_step      <= '0;
            for (int k = 0; k < col; k++) begin
                r_lanes[k] <= '0;
                r_norm[k]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_num_vec   <= i_num_vec;
                    r_sign_mode <= i_sign_mode;
                    r_idx       <= '0;
                    r_add       <= '0;
                    r_state     <= (i_num_vec == '0) ? S_DONE : S_RD;
                end
                S_RD: r_state <= S_CAP;
                S_CAP: begin
                    for (int k = 0; k < col; k++)
                        r_lanes[k] <= bus.pmem_dout[bw_psum*k +: bw_psum];
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_sum <= w_sum;
                    for (int k = 0; k < col; k++)
                        r_norm[k] <= '0;
                    r_lane  <= '0;
                    r_step  <= '0;
                    r_rem   <= sum_w'(w_dvd >> (frac + 1));
                    r_low   <= w_dvd[frac:0];
                    r_q     <= '0;
                    r_neg   <= r_sign_mode && r_lanes[0][bw_psum-1];
                    r_state <= (w_sum == '0) ? S_OUT : S_DIV;
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_low <= r_low << 1;
                    r_q   <= w_q[frac-1:0];
                    if (r_step == STEP_LAST) begin
                        r_norm[r_lane] <= signed_norm(w_q, r_neg);
                        r_step         <= '0;
                        if (r_lane == LANE_LAST) begin
                            r_state <= S_OUT;
                        end else begin
                            // Preload the next lane so no cycle is lost between lanes.
                            r_lane <= w_nxt_lane;
                            r_rem  <= sum_w'(w_dvd >> (frac + 1));
                            r_low  <= w_dvd[frac:0];
                            r_q    <= '0;
                            r_neg  <= r_sign_mode && r_lanes[w_nxt_lane][bw_psum-1];
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_OUT: if (bus.norm_ready) begin
                    r_idx <= w_idx_nxt;
                    if (w_idx_nxt == r_num_vec) begin
                        r_state <= S_DONE;
                    end else begin
                        r_add   <= w_idx_nxt[add_w-1:0];
                        r_state <= S_RD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < col; k++) begin : g_pack
        assign bus.norm_out[nw*k +: nw] = r_norm[k];
    end

    assign bus.pmem_rd    = (r_state == S_RD);
    assign bus.pmem_add   = r_add;
    assign bus.sum_out    = r_sum;
    assign bus.norm_valid = (r_state == S_OUT);
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
endmodule
